// File: rtl/fft_framer_pkg.sv
// fft_framer_pkg: shared pattern codes, frame-length clamp and complex word type for the FFT input framer
package fft_framer_pkg;

    localparam logic [1:0] PAT_PASS    = 2'd0;
    localparam logic [1:0] PAT_DC      = 2'd1;
    localparam logic [1:0] PAT_IMPULSE = 2'd2;

    localparam int CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] im;
        logic signed [CPLX_W-1:0] re;
    } cplx_t;

    // Bound a requested log2 frame length to the supported range
    function automatic int clamp_log2(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry registered AXI4-Stream buffer; ready depends only on occupancy, never on m_tready
module axis_skid_buffer #(
    parameter int W = 33
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign s_tready = aresetn && (r_cnt != 2'd2);
    assign m_tvalid = (r_cnt != 2'd0);
    assign m_tdata  = r_head;
    assign w_push   = s_tvalid && s_tready;
    assign w_pop    = m_tvalid && m_tready;

    // head always presents the oldest word; tail only fills when head is occupied and not leaving
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)))
                r_head <= s_tdata;
            else if (w_pop && r_cnt == 2'd2)
                r_head <= r_tail;
            if (w_push && r_cnt == 2'd1 && !w_pop)
                r_tail <= s_tdata;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: frames signed samples into {imag, real} AXI4-Stream words with tlast; optional DC/impulse source under FRAMER_PATTERN_EN
module fft_input_framer
    import fft_framer_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int OUT_W    = 16,
    parameter int LOG2_MAX = 10,
    parameter int LOG2_MIN = 3,
    localparam int LW      = $clog2(LOG2_MAX + 1)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [LW-1:0]       cfg_log2_len,
`ifdef FRAMER_PATTERN_EN
    input  logic [1:0]          pattern_sel,
`endif
    input  logic [SAMPLE_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [2*OUT_W-1:0]  m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                frame_done,
    output logic [15:0]         frame_count
);

    localparam int SHIFT = OUT_W - SAMPLE_W;

    logic [LOG2_MAX-1:0] r_idx;
    logic [LW-1:0]       r_log2;
    logic                r_done;
    logic [15:0]         r_count;
    logic [LW-1:0]       w_log2;
    logic [LOG2_MAX-1:0] w_last_idx;
    logic                w_last;
    logic                w_src_valid;
    logic                w_src_ready;
    logic                w_push;
    logic [OUT_W-1:0]    w_pass;
    logic [OUT_W-1:0]    w_real;
    logic [2*OUT_W:0]    w_skid_in;
    logic [2*OUT_W:0]    w_skid_out;

    // length only follows the config between frames; idx 0 can never be the last word since LOG2_MIN >= 1
    assign w_log2     = (r_idx == '0) ? LW'(clamp_log2(int'(cfg_log2_len), LOG2_MIN, LOG2_MAX)) : r_log2;
    assign w_last_idx = {LOG2_MAX{1'b1}} >> (LOG2_MAX - int'(w_log2));
    assign w_last     = (r_idx == w_last_idx);
    assign w_pass     = OUT_W'(s_axis_tdata) << SHIFT;
    assign w_push     = w_src_valid && w_src_ready;
    assign w_skid_in  = {w_last, {OUT_W{1'b0}}, w_real};

`ifdef FRAMER_PATTERN_EN
    localparam logic [OUT_W-1:0] MAX_POS = OUT_W'({1'b0, {(SAMPLE_W-1){1'b1}}}) << SHIFT;

    logic [1:0] r_pat;
    logic [1:0] w_pat;

    assign w_pat         = (r_idx != '0) ? r_pat :
                           (pattern_sel == PAT_DC || pattern_sel == PAT_IMPULSE) ? pattern_sel : PAT_PASS;
    assign w_src_valid   = (w_pat == PAT_PASS) ? s_axis_tvalid : 1'b1;
    assign s_axis_tready = (w_pat == PAT_PASS) && w_src_ready;
    assign w_real        = (w_pat == PAT_DC || (w_pat == PAT_IMPULSE && r_idx == '0)) ? MAX_POS :
                           (w_pat == PAT_IMPULSE) ? '0 : w_pass;

    // pattern choice is frozen for the whole frame, like the length
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_pat <= PAT_PASS;
        else
            r_pat <= w_pat;
    end
`else
    assign w_src_valid   = s_axis_tvalid;
    assign s_axis_tready = w_src_ready;
    assign w_real        = w_pass;
`endif

    // sample position within the frame and the length it was started with
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx  <= '0;
            r_log2 <= LW'(LOG2_MAX);
        end else begin
            r_log2 <= w_log2;
            if (w_push)
                r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    axis_skid_buffer #(.W(2*OUT_W + 1)) u_skid (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (w_skid_in),
        .s_tvalid (w_src_valid),
        .s_tready (w_src_ready),
        .m_tdata  (w_skid_out),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

    assign m_axis_tlast = w_skid_out[2*OUT_W];
    assign m_axis_tdata = w_skid_out[2*OUT_W-1:0];

    // completion pulse and counter land the cycle after the tlast word is taken
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done  <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
            r_count <= r_count + 16'(m_axis_tvalid && m_axis_tready && m_axis_tlast);
        end
    end

    assign frame_done  = r_done;
    assign frame_count = r_count;

endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: randomized self-checking bench with a queue-based reference model of the framer
module tb_fft_input_framer;

    localparam int SW   = 12;
    localparam int OW   = 16;
    localparam int LMAX = 10;
    localparam int LMIN = 3;

    logic            aclk          = 1'b0;
    logic            aresetn       = 1'b0;
    logic [3:0]      cfg_log2_len  = 4'd10;
    logic [1:0]      pattern_sel   = 2'd0;
    logic [SW-1:0]   s_axis_tdata  = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [2*OW-1:0] m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic            m_axis_tlast;
    logic            frame_done;
    logic [15:0]     frame_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t q[$];
    int    frames[$];
    int    m_idx    = 0;
    int    m_len    = 1024;
    int    m_pat    = 0;
    int    exp_cnt  = 0;
    int    run      = 0;
    int    cyc      = 0;
    logic  exp_done = 1'b0;
    bit    rand_ready = 1'b0;
    bit    in_hs;
    bit    out_hs;

    always #5 aclk = ~aclk;

    fft_input_framer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_log2_len  (cfg_log2_len),
`ifdef FRAMER_PATTERN_EN
        .pattern_sel   (pattern_sel),
`endif
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int clampf(input int v);
        return (v < LMIN) ? LMIN : (v > LMAX) ? LMAX : v;
    endfunction

    // one clock: compare DUT against the model, then advance the model by the handshakes of that edge
    task automatic tick();
        int    p;
        word_t w;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        #1;
        if (!aresetn) begin
            q.delete();
            m_idx = 0; m_pat = 0; exp_done = 1'b0; exp_cnt = 0; run = 0;
            check("rst_tdata", m_axis_tdata, 0);
            check("rst_tlast", m_axis_tlast, 0);
        end
        p = (m_idx != 0) ? m_pat : (pattern_sel == 2'd1 || pattern_sel == 2'd2) ? int'(pattern_sel) : 0;
        if (m_idx == 0) m_len = 1 << clampf(int'(cfg_log2_len));
        check("s_tready", s_axis_tready, aresetn && p == 0 && q.size() < 2);
        check("m_tvalid", m_axis_tvalid, q.size() != 0);
        if (m_axis_tvalid && q.size() != 0) begin
            check("m_tdata", m_axis_tdata, q[0].data);
            check("m_tlast", m_axis_tlast, q[0].last);
        end
        check("frame_done", frame_done, exp_done);
        check("frame_count", frame_count, 16'(exp_cnt));
        in_hs  = aresetn && ((p != 0) ? (q.size() < 2) : (s_axis_tvalid && s_axis_tready));
        out_hs = m_axis_tvalid && m_axis_tready && q.size() != 0;
        @(posedge aclk);
        #1;
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL watchdog cycles=%0d limit=60000", cyc);
            $fatal(1, "watchdog");
        end
        exp_done = out_hs ? q[0].last : 1'b0;
        if (out_hs) begin
            if (q[0].last) begin
                exp_cnt++;
                frames.push_back(run + 1);
                run = 0;
            end else begin
                run++;
            end
            void'(q.pop_front());
        end
        if (in_hs) begin
            if (m_idx == 0) m_pat = p;
            w.last = (m_idx == m_len - 1);
            w.data = (p == 1) ? 32'h0000_7FF0 :
                     (p == 2) ? ((m_idx == 0) ? 32'h0000_7FF0 : 32'h0) :
                     {16'h0, s_axis_tdata, 4'h0};
            m_idx = w.last ? 0 : m_idx + 1;
            q.push_back(w);
        end
    endtask

    task automatic send(input logic [SW-1:0] d);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        do begin
            tick();
            n++;
        end while (!in_hs && n < 200);
        check("send_accept", in_hs, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        s_axis_tvalid = 1'b0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", q.size(), 0);
        tick();
    endtask

    initial begin
        int f0;
        int n;

        // reset state
        repeat (3) tick();
        check("rst_count_hold", frame_count, 0);
        aresetn = 1'b1;
        tick();

        // full-length frame of max-positive samples, no backpressure
        cfg_log2_len  = 4'd10;
        m_axis_tready = 1'b1;
        f0 = frames.size();
        for (int i = 0; i < 1024; i++) send(12'h7FF);
        drain();
        check("t1_frames", frames.size() - f0, 1);
        check("t1_len", frames[f0], 1024);
        check("t1_count", frame_count, 1);

        // short frames, ramp input, random gaps and backpressure
        cfg_log2_len = 4'd3;
        rand_ready   = 1'b1;
        f0 = frames.size();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                tick();
            end
            send(SW'(i));
        end
        drain();
        check("t2_frames", frames.size() - f0, 8);
        for (int k = 0; k < 8; k++) check("t2_len", frames[f0 + k], 8);
        check("t2_count", frame_count, 9);

        // length change mid-frame only applies to the following frame
        cfg_log2_len = 4'd10;
        f0 = frames.size();
        for (int i = 0; i < 1040; i++) begin
            if (i == 500) cfg_log2_len = 4'd4;
            send(SW'($urandom));
        end
        drain();
        check("t3_first", frames[f0], 1024);
        check("t3_second", frames[f0 + 1], 16);

        // out-of-range lengths clamp
        cfg_log2_len = 4'd15;
        f0 = frames.size();
        for (int i = 0; i < 1024; i++) send(SW'($urandom));
        drain();
        check("clamp_hi", frames[f0], 1024);
        cfg_log2_len = 4'd1;
        for (int i = 0; i < 8; i++) send(SW'($urandom));
        drain();
        check("clamp_lo", frames[f0 + 1], 8);
        check("clamp_frames", frames.size() - f0, 2);

        // reset mid-frame with the buffer full
        cfg_log2_len  = 4'd10;
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 300; i++) send(SW'($urandom));
        m_axis_tready = 1'b0;
        send(SW'($urandom));
        s_axis_tvalid = 1'b0;
        tick();
        check("full_before_rst", s_axis_tready, 0);
        aresetn = 1'b0;
        repeat (3) tick();
        check("rst_mid_valid", m_axis_tvalid, 0);
        check("rst_mid_count", frame_count, 0);
        aresetn = 1'b1;
        tick();
        check("rst_release_ready", s_axis_tready, 1);
        rand_ready = 1'b1;
        f0 = frames.size();
        for (int i = 0; i < 1024; i++) send(SW'($urandom));
        drain();
        check("t5_len", frames[f0], 1024);
        check("t5_count", frame_count, 1);

`ifdef FRAMER_PATTERN_EN
        // impulse pattern, external source ignored
        cfg_log2_len  = 4'd4;
        pattern_sel   = 2'd2;
        s_axis_tvalid = 1'b0;
        f0 = frames.size();
        n = 0;
        while (frames.size() < f0 + 3 && n < 600) begin
            tick();
            n++;
        end
        check("pat_frames", frames.size() - f0, 3);
        for (int k = 0; k < 3; k++) check("pat_len", frames[f0 + k], 16);
        pattern_sel = 2'd0;
        n = 0;
        while (!(m_idx == 0 && q.size() == 0) && n < 400) begin
            tick();
            n++;
        end
        check("pat_stop", q.size(), 0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
